cpu_run_monitor: RTL

- Parametrised run controller and trace capture for the single-cycle CPU.
- Starts a run, counts cycles, detects halt (PC stable) or timeout, and records every register-file write and data-memory write, with its cycle stamp, into an event FIFO.
- A ready/valid port drains the FIFO. This replaces fixed-length runs and full-state dumps every cycle with event-driven logging.
- Instantiated beside Simple_Single_CPU and fed from its PC, register-file write port and data-memory write port.

---
 rtl/cpu_run_monitor_if.sv | 26 ++
 rtl/cpu_run_monitor.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor_if.sv
// Event drain channel of the run monitor: ready/valid handshake plus the
// captured event payload (kind, address, data, cycle stamp).
interface cpu_run_monitor_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) ();
  logic          evt_valid;
  logic          evt_ready;
  logic          evt_kind;
  logic [AW-1:0] evt_addr;
  logic [DW-1:0] evt_data;
  logic [CW-1:0] evt_cycle;

  // Producer side: the monitor owns the FIFO head.
  modport master (
    output evt_valid, evt_kind, evt_addr, evt_data, evt_cycle,
    input  evt_ready
  );

  // Consumer side: whoever drains the trace.
  modport slave (
    input  evt_valid, evt_kind, evt_addr, evt_data, evt_cycle,
    output evt_ready
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run controller and write-trace capture for the single-cycle CPU.
// Starts a run, counts cycles, stops on a stable PC (halt) or on the cycle
// budget (timeout), and queues every register/memory write with its cycle
// stamp into a small FIFO drained over a ready/valid channel.
module cpu_run_monitor #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int CW          = 16,
  parameter int DEPTH       = 8,
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 140
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [AW-1:0]     pc_i,
  input  logic              reg_we_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic [DW-1:0]     reg_wdata_i,
  input  logic              mem_we_i,
  input  logic [AW-1:0]     mem_addr_i,
  input  logic [DW-1:0]     mem_wdata_i,
  cpu_run_monitor_if.master evt,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic [CW-1:0]     cycle_count_o,
  output logic [15:0]       drop_count_o
);

  localparam int PW = $clog2(DEPTH);        // FIFO index width
  localparam int SW = $clog2(HALT_CYCLES);  // stable counter width, holds HALT_CYCLES-1
  localparam int EW = 1 + AW + DW + CW;     // entry = {kind, addr, data, cycle}

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cycle_count_reg;
  logic [15:0]   drop_count_reg, drop_count_next;
  logic [SW-1:0] stable_reg;
  logic [AW-1:0] last_pc_reg;

  logic [PW:0]   wr_ptr_reg, rd_ptr_reg;
  logic [EW-1:0] entry_mem [DEPTH];

  logic          run_active;
  logic          pc_same, halt_hit, budget_hit;
  logic          fifo_empty, pop;
  logic [PW:0]   used_slots, free_slots;
  logic          cap_reg, cap_mem, push_reg, push_mem;
  logic [1:0]    drops;
  logic [16:0]   drop_sum;
  logic [PW-1:0] wr_idx, mem_idx;
  logic [EW-1:0] reg_entry, mem_entry, head;

  // Halt fires on the cycle the stable counter would reach HALT_CYCLES-1,
  // i.e. the PC has been seen unchanged for HALT_CYCLES consecutive samples.
  assign pc_same    = (pc_i == last_pc_reg);
  assign halt_hit   = pc_same && (stable_reg == SW'(HALT_CYCLES - 2));
  assign budget_hit = (cycle_count_reg == CW'(MAX_CYCLES - 1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; halt takes priority over timeout in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_i) state_next = S_RUN;
      S_RUN: begin
        if (halt_hit)        state_next = S_HALTED;
        else if (budget_hit) state_next = S_TIMEOUT;
      end
      default: state_next = state_reg;
    endcase
  end

  // Decoded state outputs.
  always_comb begin
    run_active = (state_reg == S_RUN);
    state_o    = state_reg;
    done_o     = (state_reg == S_HALTED) || (state_reg == S_TIMEOUT);
  end

  // FIFO occupancy; free space is counted after this cycle's pop so a full
  // FIFO that is being drained can still accept a write.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign pop        = !fifo_empty && evt.evt_ready;
  assign used_slots = wr_ptr_reg - rd_ptr_reg;
  assign free_slots = (PW+1)'(DEPTH) - used_slots + (PW+1)'(pop);

  // Register event has priority for the first free slot.
  assign cap_reg  = run_active && reg_we_i;
  assign cap_mem  = run_active && mem_we_i;
  assign push_reg = cap_reg && (free_slots != '0);
  assign push_mem = cap_mem && (free_slots > (PW+1)'(push_reg));

  // Lost events, saturating at all-ones.
  assign drops           = 2'(cap_reg && !push_reg) + 2'(cap_mem && !push_mem);
  assign drop_sum        = 17'(drop_count_reg) + 17'(drops);
  assign drop_count_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  assign wr_idx    = wr_ptr_reg[PW-1:0];
  assign mem_idx   = wr_idx + PW'(push_reg);
  assign reg_entry = {1'b0, {(AW-5){1'b0}}, reg_waddr_i, reg_wdata_i, cycle_count_reg};
  assign mem_entry = {1'b1, mem_addr_i, mem_wdata_i, cycle_count_reg};

  // Run counters: cleared on start, advanced only while running, frozen after.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_count_reg <= '0;
      drop_count_reg  <= '0;
      stable_reg      <= '0;
      last_pc_reg     <= '0;
    end else if (state_reg == S_IDLE) begin
      if (start_i) begin
        cycle_count_reg <= '0;
        drop_count_reg  <= '0;
        stable_reg      <= '0;
        last_pc_reg     <= pc_i;
      end
    end else if (run_active) begin
      cycle_count_reg <= cycle_count_reg + CW'(1);
      drop_count_reg  <= drop_count_next;
      stable_reg      <= pc_same ? stable_reg + SW'(1) : '0;
      last_pc_reg     <= pc_i;
    end
  end

  // FIFO pointers; extra MSB distinguishes full from empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + (PW+1)'(push_reg) + (PW+1)'(push_mem);
      rd_ptr_reg <= rd_ptr_reg + (PW+1)'(pop);
    end
  end

  // Entry storage; up to two writes per cycle at consecutive slots.
  always_ff @(posedge clk_i) begin
    if (push_reg) entry_mem[wr_idx]  <= reg_entry;
    if (push_mem) entry_mem[mem_idx] <= mem_entry;
  end

  // Head of queue, zeroed when empty so idle outputs read as 0.
  assign head            = entry_mem[rd_ptr_reg[PW-1:0]];
  assign evt.evt_valid   = !fifo_empty;
  assign evt.evt_kind    = fifo_empty ? 1'b0 : head[EW-1];
  assign evt.evt_addr    = fifo_empty ? '0   : head[CW+DW +: AW];
  assign evt.evt_data    = fifo_empty ? '0   : head[CW +: DW];
  assign evt.evt_cycle   = fifo_empty ? '0   : head[CW-1:0];

  assign cycle_count_o = cycle_count_reg;
  assign drop_count_o  = drop_count_reg;

endmodule
